// File: rtl/fu_lza_arb_pkg.sv
// Shared types and default sizing for the LZA issue-slot arbiter.
package fu_lza_arb_pkg;

  localparam int TAG_W_DEF      = 4;
  localparam int FIFO_DEPTH_DEF = 2;
  localparam int STARVE_MAX_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef logic [TAG_W_DEF-1:0] tag_t;

  // One ex4/ex5 tracking slot.
  typedef struct packed {
    logic vld;
    logic is_dsq;
    tag_t tag;
  } trk_t;

endpackage

// File: rtl/fu_lza_arb_fifo.sv
// Request buffer for dsq tags: registered occupancy count, power-of-2 depth,
// pointers wrap naturally.
module fu_lza_arb_fifo
  import fu_lza_arb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int W     = TAG_W_DEF
) (
  input  logic         nclk,
  input  logic         reset_b,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         not_empty,
  output logic         rdy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push_en, pop_en;

  // rdy looks only at the registered count, so a full buffer refuses a push
  // even in a cycle where it is also being popped.
  assign rdy       = (count < FULL_CNT);
  assign not_empty = (count != '0);
  assign push_en   = push & rdy;
  assign pop_en    = pop & not_empty;
  assign head      = mem[rd_ptr];

  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge values of its neighbours.
  always_ff @(posedge nclk) begin
    if (!reset_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; the count and pointers alone say what is valid.
  always_ff @(posedge nclk) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fu_lza_arb.sv
// Arbiter/sequencer for the shared LZA: ex3 slot grant, ex4/ex5 completion
// tracking, optional dsq starvation control (FU_LZA_ARB_STARVE_EN).
module fu_lza_arb
  import fu_lza_arb_pkg::*;
#(
  parameter int TAG_W      = TAG_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic             nclk,
  input  logic             reset_b,
  input  logic             flush,
  input  logic             pipe_ex3_vld,
  input  logic             dsq_req_vld,
  input  logic [TAG_W-1:0] dsq_req_tag,
  output logic             dsq_req_rdy,
  output logic             sel_dsq_ex3,
  output logic             lza_act_ex3,
  output logic             pipe_rsp_vld_ex5,
  output logic             dsq_rsp_vld_ex5,
  output logic [TAG_W-1:0] dsq_rsp_tag_ex5,
  output logic             hold_pipe_ex2,
  output logic             proto_err
);

  logic             fifo_ne, fifo_rdy, grant_dsq, push;
  logic [TAG_W-1:0] fifo_head;
  trk_t             ex4_q, ex5_q, ex4_d, ex5_d;

  // Every output is qualified by reset_b so a reset cycle shows all zeros and
  // completions already in ex4/ex5 are dropped rather than returned.
  assign dsq_req_rdy = reset_b & fifo_rdy;
  assign push        = dsq_req_vld & dsq_req_rdy;
  assign grant_dsq   = reset_b & ~pipe_ex3_vld & fifo_ne;
  assign sel_dsq_ex3 = grant_dsq;
  assign lza_act_ex3 = reset_b & (pipe_ex3_vld | grant_dsq);

  fu_lza_arb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (TAG_W)
  ) u_fifo (
    .nclk      (nclk),
    .reset_b   (reset_b),
    .push      (push),
    .push_data (dsq_req_tag),
    .pop       (grant_dsq),
    .head      (fifo_head),
    .not_empty (fifo_ne),
    .rdy       (fifo_rdy)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ex4_d        = '0;
    ex4_d.vld    = grant_dsq | (pipe_ex3_vld & ~flush);
    ex4_d.is_dsq = grant_dsq;
    ex4_d.tag    = grant_dsq ? tag_t'(fifo_head) : '0;
    ex5_d        = ex4_q;
    if (flush && !ex4_q.is_dsq) ex5_d.vld = 1'b0;
  end

  always_ff @(posedge nclk) begin
    if (!reset_b) begin
      ex4_q <= '0;
      ex5_q <= '0;
    end else begin
      ex4_q <= ex4_d;
      ex5_q <= ex5_d;
    end
  end

  assign pipe_rsp_vld_ex5 = reset_b & ex5_q.vld & ~ex5_q.is_dsq;
  assign dsq_rsp_vld_ex5  = reset_b & ex5_q.vld & ex5_q.is_dsq;
  assign dsq_rsp_tag_ex5  = dsq_rsp_vld_ex5 ? TAG_W'(ex5_q.tag) : '0;

`ifdef FU_LZA_ARB_STARVE_EN
  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam logic [SCW-1:0] CNT_LAST = SCW'(STARVE_MAX - 1);

  state_e         state_q, state_d;
  logic [SCW-1:0] cnt_q, cnt_d;
  logic           perr_q, perr_d, hold, blocked;

  assign blocked = pipe_ex3_vld & fifo_ne;

  // The counter tallies blocked cycles including the one that leaves IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    perr_d  = perr_q;
    hold    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (blocked) begin
          state_d = ST_WAIT;
          cnt_d   = SCW'(1);
        end
      end
      ST_WAIT: begin
        if (grant_dsq) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (blocked) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            hold    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // Upstream was told to bubble this slot; a pipe op here is a violation.
        if (pipe_ex3_vld) begin
          perr_d  = 1'b1;
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge nclk) begin
    if (!reset_b) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perr_q  <= perr_d;
    end
  end

  assign hold_pipe_ex2 = reset_b & hold;
  assign proto_err     = reset_b & perr_q;
`else
  assign hold_pipe_ex2 = 1'b0;
  assign proto_err     = 1'b0;
`endif

endmodule

// File: tb/tb_fu_lza_arb.sv
// Directed bench for fu_lza_arb; starvation scenario depends on FU_LZA_ARB_STARVE_EN.
module tb_fu_lza_arb;

  logic       nclk = 1'b0;
  logic       reset_b;
  logic       flush;
  logic       pipe_ex3_vld;
  logic       dsq_req_vld;
  logic [3:0] dsq_req_tag;
  logic       dsq_req_rdy, sel_dsq_ex3, lza_act_ex3, pipe_rsp_vld_ex5;
  logic       dsq_rsp_vld_ex5, hold_pipe_ex2, proto_err;
  logic [3:0] dsq_rsp_tag_ex5;

  int checks = 0;
  int errors = 0;

  always #5 nclk = ~nclk;

  fu_lza_arb dut (
    .nclk             (nclk),
    .reset_b          (reset_b),
    .flush            (flush),
    .pipe_ex3_vld     (pipe_ex3_vld),
    .dsq_req_vld      (dsq_req_vld),
    .dsq_req_tag      (dsq_req_tag),
    .dsq_req_rdy      (dsq_req_rdy),
    .sel_dsq_ex3      (sel_dsq_ex3),
    .lza_act_ex3      (lza_act_ex3),
    .pipe_rsp_vld_ex5 (pipe_rsp_vld_ex5),
    .dsq_rsp_vld_ex5  (dsq_rsp_vld_ex5),
    .dsq_rsp_tag_ex5  (dsq_rsp_tag_ex5),
    .hold_pipe_ex2    (hold_pipe_ex2),
    .proto_err        (proto_err)
  );

  // Inputs change 2 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic adv();
    @(posedge nclk);
    #2;
  endtask

  task automatic drive(input logic p, input logic f, input logic v, input logic [3:0] t);
    pipe_ex3_vld = p;
    flush        = f;
    dsq_req_vld  = v;
    dsq_req_tag  = t;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      adv();
      drive(1'b0, 1'b0, 1'b0, 4'h0);
    end
  endtask

  task automatic test_reset();
    reset_b = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    adv();
    adv();
    #1;
    checks++;
    if ({dsq_req_rdy, sel_dsq_ex3, lza_act_ex3, pipe_rsp_vld_ex5, dsq_rsp_vld_ex5,
         dsq_rsp_tag_ex5, hold_pipe_ex2, proto_err} !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b sel=%b act=%b prsp=%b drsp=%b tag=%h hold=%b perr=%b, want all 0",
               dsq_req_rdy, sel_dsq_ex3, lza_act_ex3, pipe_rsp_vld_ex5, dsq_rsp_vld_ex5,
               dsq_rsp_tag_ex5, hold_pipe_ex2, proto_err);
    end
    adv();
    reset_b = 1'b1;
    adv();
    #1;
    checks++;
    if (dsq_req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy_rise: got %b want 1", dsq_req_rdy);
    end
    checks++;
    if (sel_dsq_ex3 !== 1'b0 || lza_act_ex3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_slot: got sel=%b act=%b want 0 0", sel_dsq_ex3, lza_act_ex3);
    end
  endtask

  task automatic test_pipe();
    adv();
    drive(1'b1, 1'b0, 1'b0, 4'h0);
    checks++;
    if (lza_act_ex3 !== 1'b1 || sel_dsq_ex3 !== 1'b0) begin
      errors++;
      $display("FAIL pipe_grant: got act=%b sel=%b want 1 0", lza_act_ex3, sel_dsq_ex3);
    end
    adv();
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    checks++;
    if (pipe_rsp_vld_ex5 !== 1'b0) begin
      errors++;
      $display("FAIL pipe_early: got %b want 0", pipe_rsp_vld_ex5);
    end
    adv();
    checks++;
    if (pipe_rsp_vld_ex5 !== 1'b1 || dsq_rsp_vld_ex5 !== 1'b0) begin
      errors++;
      $display("FAIL pipe_rsp: got prsp=%b drsp=%b want 1 0", pipe_rsp_vld_ex5, dsq_rsp_vld_ex5);
    end
    idle(2);
  endtask

  task automatic test_dsq_only();
    adv();
    drive(1'b0, 1'b0, 1'b1, 4'h3);
    checks++;
    if (dsq_req_rdy !== 1'b1 || sel_dsq_ex3 !== 1'b0) begin
      errors++;
      $display("FAIL dsq_push: got rdy=%b sel=%b want 1 0", dsq_req_rdy, sel_dsq_ex3);
    end
    adv();
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    checks++;
    if (sel_dsq_ex3 !== 1'b1 || lza_act_ex3 !== 1'b1) begin
      errors++;
      $display("FAIL dsq_grant: got sel=%b act=%b want 1 1", sel_dsq_ex3, lza_act_ex3);
    end
    adv();
    checks++;
    if (sel_dsq_ex3 !== 1'b0 || dsq_rsp_vld_ex5 !== 1'b0) begin
      errors++;
      $display("FAIL dsq_ex4: got sel=%b drsp=%b want 0 0", sel_dsq_ex3, dsq_rsp_vld_ex5);
    end
    adv();
    checks++;
    if (dsq_rsp_vld_ex5 !== 1'b1 || dsq_rsp_tag_ex5 !== 4'h3 || pipe_rsp_vld_ex5 !== 1'b0) begin
      errors++;
      $display("FAIL dsq_rsp: got vld=%b tag=%h prsp=%b want 1 3 0",
               dsq_rsp_vld_ex5, dsq_rsp_tag_ex5, pipe_rsp_vld_ex5);
    end
    adv();
    checks++;
    if (dsq_rsp_vld_ex5 !== 1'b0) begin
      errors++;
      $display("FAIL dsq_rsp_single: got %b want 0", dsq_rsp_vld_ex5);
    end
    idle(1);
  endtask

  task automatic test_contention();
    adv();
    drive(1'b1, 1'b0, 1'b1, 4'h1);
    adv();
    drive(1'b1, 1'b0, 1'b1, 4'h2);
    checks++;
    if (dsq_req_rdy !== 1'b1 || sel_dsq_ex3 !== 1'b0) begin
      errors++;
      $display("FAIL cont_second_push: got rdy=%b sel=%b want 1 0", dsq_req_rdy, sel_dsq_ex3);
    end
    for (int i = 0; i < 2; i++) begin
      adv();
      drive(1'b1, 1'b0, 1'b0, 4'h0);
      checks++;
      if (dsq_req_rdy !== 1'b0 || sel_dsq_ex3 !== 1'b0 || lza_act_ex3 !== 1'b1) begin
        errors++;
        $display("FAIL cont_blocked[%0d]: got rdy=%b sel=%b act=%b want 0 0 1",
                 i, dsq_req_rdy, sel_dsq_ex3, lza_act_ex3);
      end
    end
    adv();
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    checks++;
    if (sel_dsq_ex3 !== 1'b1 || lza_act_ex3 !== 1'b1) begin
      errors++;
      $display("FAIL cont_grant1: got sel=%b act=%b want 1 1", sel_dsq_ex3, lza_act_ex3);
    end
    adv();
    checks++;
    if (sel_dsq_ex3 !== 1'b1 || dsq_req_rdy !== 1'b1 || pipe_rsp_vld_ex5 !== 1'b1) begin
      errors++;
      $display("FAIL cont_grant2: got sel=%b rdy=%b prsp=%b want 1 1 1",
               sel_dsq_ex3, dsq_req_rdy, pipe_rsp_vld_ex5);
    end
    adv();
    checks++;
    if (dsq_rsp_vld_ex5 !== 1'b1 || dsq_rsp_tag_ex5 !== 4'h1 || sel_dsq_ex3 !== 1'b0) begin
      errors++;
      $display("FAIL cont_rsp1: got vld=%b tag=%h sel=%b want 1 1 0",
               dsq_rsp_vld_ex5, dsq_rsp_tag_ex5, sel_dsq_ex3);
    end
    adv();
    checks++;
    if (dsq_rsp_vld_ex5 !== 1'b1 || dsq_rsp_tag_ex5 !== 4'h2) begin
      errors++;
      $display("FAIL cont_rsp2: got vld=%b tag=%h want 1 2", dsq_rsp_vld_ex5, dsq_rsp_tag_ex5);
    end
    idle(2);
  endtask

  task automatic test_full_push_pop();
    logic [3:0] exp_tag [3];
    exp_tag[0] = 4'h5;
    exp_tag[1] = 4'h6;
    exp_tag[2] = 4'h8;
    adv();
    drive(1'b1, 1'b0, 1'b1, 4'h5);
    adv();
    drive(1'b1, 1'b0, 1'b1, 4'h6);
    adv();
    drive(1'b0, 1'b0, 1'b1, 4'h7);
    checks++;
    if (dsq_req_rdy !== 1'b0 || sel_dsq_ex3 !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_push: got rdy=%b sel=%b want 0 1", dsq_req_rdy, sel_dsq_ex3);
    end
    adv();
    drive(1'b0, 1'b0, 1'b1, 4'h8);
    checks++;
    if (dsq_req_rdy !== 1'b1 || sel_dsq_ex3 !== 1'b1) begin
      errors++;
      $display("FAIL full_rdy_back: got rdy=%b sel=%b want 1 1", dsq_req_rdy, sel_dsq_ex3);
    end
    adv();
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      if (i != 0) adv();
      checks++;
      if (dsq_rsp_vld_ex5 !== 1'b1 || dsq_rsp_tag_ex5 !== exp_tag[i]) begin
        errors++;
        $display("FAIL full_rsp[%0d]: got vld=%b tag=%h want 1 %h",
                 i, dsq_rsp_vld_ex5, dsq_rsp_tag_ex5, exp_tag[i]);
      end
    end
    adv();
    checks++;
    if (dsq_rsp_vld_ex5 !== 1'b0 || sel_dsq_ex3 !== 1'b0) begin
      errors++;
      $display("FAIL full_drained: got drsp=%b sel=%b want 0 0", dsq_rsp_vld_ex5, sel_dsq_ex3);
    end
    idle(2);
  endtask

  task automatic test_flush();
    adv();
    drive(1'b1, 1'b0, 1'b1, 4'h9);
    adv();
    drive(1'b0, 1'b1, 1'b0, 4'h0);
    checks++;
    if (sel_dsq_ex3 !== 1'b1) begin
      errors++;
      $display("FAIL flush_dsq_grant: got %b want 1", sel_dsq_ex3);
    end
    adv();
    drive(1'b0, 1'b1, 1'b0, 4'h0);
    checks++;
    if (pipe_rsp_vld_ex5 !== 1'b0 || dsq_rsp_vld_ex5 !== 1'b0) begin
      errors++;
      $display("FAIL flush_ex4_kill: got prsp=%b drsp=%b want 0 0", pipe_rsp_vld_ex5, dsq_rsp_vld_ex5);
    end
    adv();
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    checks++;
    if (dsq_rsp_vld_ex5 !== 1'b1 || dsq_rsp_tag_ex5 !== 4'h9 || pipe_rsp_vld_ex5 !== 1'b0) begin
      errors++;
      $display("FAIL flush_dsq_survive: got vld=%b tag=%h prsp=%b want 1 9 0",
               dsq_rsp_vld_ex5, dsq_rsp_tag_ex5, pipe_rsp_vld_ex5);
    end
    adv();
    drive(1'b0, 1'b0, 1'b1, 4'hB);
    adv();
    drive(1'b1, 1'b1, 1'b0, 4'h0);
    checks++;
    if (sel_dsq_ex3 !== 1'b0 || lza_act_ex3 !== 1'b1) begin
      errors++;
      $display("FAIL flush_ex3_slot: got sel=%b act=%b want 0 1", sel_dsq_ex3, lza_act_ex3);
    end
    adv();
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    checks++;
    if (sel_dsq_ex3 !== 1'b1) begin
      errors++;
      $display("FAIL flush_next_grant: got %b want 1", sel_dsq_ex3);
    end
    adv();
    checks++;
    if (pipe_rsp_vld_ex5 !== 1'b0) begin
      errors++;
      $display("FAIL flush_ex3_kill: got %b want 0", pipe_rsp_vld_ex5);
    end
    adv();
    checks++;
    if (dsq_rsp_vld_ex5 !== 1'b1 || dsq_rsp_tag_ex5 !== 4'hB) begin
      errors++;
      $display("FAIL flush_dsq_b: got vld=%b tag=%h want 1 b", dsq_rsp_vld_ex5, dsq_rsp_tag_ex5);
    end
    idle(2);
  endtask

`ifdef FU_LZA_ARB_STARVE_EN
  task automatic starve_round(input logic [3:0] tag, input logic pipe_in_held, input int round);
    logic exp_hold;
    adv();
    drive(1'b1, 1'b0, 1'b1, tag);
    for (int i = 1; i <= 8; i++) begin
      adv();
      drive(1'b1, 1'b0, 1'b0, 4'h0);
      exp_hold = (i == 8);
      checks++;
      if (hold_pipe_ex2 !== exp_hold || sel_dsq_ex3 !== 1'b0) begin
        errors++;
        $display("FAIL starve_hold[r%0d c%0d]: got hold=%b sel=%b want %b 0",
                 round, i, hold_pipe_ex2, sel_dsq_ex3, exp_hold);
      end
    end
    adv();
    drive(pipe_in_held, 1'b0, 1'b0, 4'h0);
    checks++;
    if (sel_dsq_ex3 !== ~pipe_in_held || hold_pipe_ex2 !== 1'b0 || lza_act_ex3 !== 1'b1) begin
      errors++;
      $display("FAIL starve_held_slot[r%0d]: got sel=%b hold=%b act=%b want %b 0 1",
               round, sel_dsq_ex3, hold_pipe_ex2, lza_act_ex3, ~pipe_in_held);
    end
  endtask

  task automatic test_starvation();
    starve_round(4'hA, 1'b0, 0);
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL starve_no_err: got %b want 0", proto_err);
    end
    adv();
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    adv();
    checks++;
    if (dsq_rsp_vld_ex5 !== 1'b1 || dsq_rsp_tag_ex5 !== 4'hA) begin
      errors++;
      $display("FAIL starve_rsp: got vld=%b tag=%h want 1 a", dsq_rsp_vld_ex5, dsq_rsp_tag_ex5);
    end
    idle(2);
    starve_round(4'hC, 1'b1, 1);
    adv();
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    checks++;
    if (proto_err !== 1'b1 || sel_dsq_ex3 !== 1'b1) begin
      errors++;
      $display("FAIL starve_proto_err: got perr=%b sel=%b want 1 1", proto_err, sel_dsq_ex3);
    end
    idle(3);
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL starve_err_sticky: got %b want 1", proto_err);
    end
  endtask
`else
  task automatic test_starvation();
    adv();
    drive(1'b1, 1'b0, 1'b1, 4'hA);
    for (int i = 1; i <= 12; i++) begin
      adv();
      drive(1'b1, 1'b0, 1'b0, 4'h0);
      checks++;
      if (hold_pipe_ex2 !== 1'b0 || sel_dsq_ex3 !== 1'b0 || proto_err !== 1'b0) begin
        errors++;
        $display("FAIL nostarve_blocked[%0d]: got hold=%b sel=%b perr=%b want 0 0 0",
                 i, hold_pipe_ex2, sel_dsq_ex3, proto_err);
      end
    end
    adv();
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    checks++;
    if (sel_dsq_ex3 !== 1'b1) begin
      errors++;
      $display("FAIL nostarve_grant: got %b want 1", sel_dsq_ex3);
    end
    idle(3);
  endtask
`endif

  task automatic test_reset_midflight();
    adv();
    drive(1'b0, 1'b0, 1'b1, 4'h4);
    adv();
    drive(1'b0, 1'b0, 1'b1, 4'h5);
    adv();
    drive(1'b0, 1'b0, 1'b1, 4'h6);
    adv();
    reset_b = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    checks++;
    if ({dsq_req_rdy, sel_dsq_ex3, lza_act_ex3, pipe_rsp_vld_ex5, dsq_rsp_vld_ex5,
         dsq_rsp_tag_ex5, hold_pipe_ex2, proto_err} !== 11'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got rdy=%b sel=%b act=%b prsp=%b drsp=%b tag=%h hold=%b perr=%b, want all 0",
               dsq_req_rdy, sel_dsq_ex3, lza_act_ex3, pipe_rsp_vld_ex5, dsq_rsp_vld_ex5,
               dsq_rsp_tag_ex5, hold_pipe_ex2, proto_err);
    end
    adv();
    reset_b = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) adv();
      checks++;
      if (dsq_rsp_vld_ex5 !== 1'b0 || sel_dsq_ex3 !== 1'b0 || dsq_req_rdy !== 1'b1 || proto_err !== 1'b0) begin
        errors++;
        $display("FAIL midrst_after[%0d]: got drsp=%b sel=%b rdy=%b perr=%b want 0 0 1 0",
                 i, dsq_rsp_vld_ex5, sel_dsq_ex3, dsq_req_rdy, proto_err);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_b      = 1'b0;
    flush        = 1'b0;
    pipe_ex3_vld = 1'b0;
    dsq_req_vld  = 1'b0;
    dsq_req_tag  = 4'h0;
    test_reset();
    test_pipe();
    test_dsq_only();
    test_contention();
    test_full_push_pop();
    test_flush();
    test_starvation();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
